key_expansion: RTL and testbench
================================

KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 SHALL expose: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL expose: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL expose: enableKeyExp  input  1  start request, sampled at each rising edge.
REQ-004 SHALL expose: key  input  256  AES-256 cipher key, MSB-first numbering [0:255]; byte 0 = key[0:7].
REQ-005 SHALL expose: keyExp  output  1920  expanded key, 60 words of 32 bits; word i at keyExp[32i : 32i+31]; feeds the round-key selector.
REQ-006 SHALL expose: keyExpBusy  output  1  high while expansion is in progress.
REQ-007 SHALL expose: keyExpDone  output  1  high once all 60 words are valid; held until the next accepted start or reset.

Function
REQ-008 SHALL implement FIPS-197 AES-256 key expansion: Nk=8, Nr=14, 60 words.
REQ-009 SHALL use FSM states IDLE, EXPAND, DONE; reset state IDLE.
REQ-010 IDLE or DONE with enableKeyExp=1 at edge N: SHALL write words 0..7 from key, set index=8, clear keyExpDone, set keyExpBusy, go to EXPAND.
REQ-011 EXPAND: SHALL compute exactly one word per edge, w[i] = w[i-8] XOR temp, where temp = w[i-1] by default.
REQ-012 For i mod 8 = 0, temp SHALL be SubWord(RotWord(w[i-1])) XOR {Rcon[i/8],00,00,00}, Rcon[1..7] = 01,02,04,08,10,20,40.
REQ-013 For i mod 8 = 4, temp SHALL be SubWord(w[i-1]).
REQ-014 The edge that writes word 59 SHALL be edge N+52; at that edge keyExpBusy SHALL go to 0, keyExpDone to 1, and the state to DONE.
REQ-015 Total latency from start sampled to keyExpDone high SHALL be 52 cycles.
REQ-016 enableKeyExp while in EXPAND SHALL be ignored; expansion continues unaffected.
REQ-017 The key input SHALL be sampled only at the start edge; later key changes SHALL have no effect on the run in progress.
REQ-018 Words not yet rewritten during a run SHALL retain their prior values; consumers use keyExp only while keyExpDone=1.
REQ-019 A held-high enableKeyExp SHALL restart a run each time the FSM is in DONE; level-start is permitted.
REQ-020 keyExpBusy and keyExpDone SHALL never be high simultaneously.
REQ-021 The index counter SHALL be 6 bits, ranging 8..59, and SHALL never wrap.

Reset
REQ-022 rst=1 at an edge SHALL force the state to IDLE, keyExp to all zeros, keyExpBusy=0, keyExpDone=0, and index=0, overriding any simultaneous enableKeyExp.
REQ-023 Reset mid-EXPAND SHALL abort the run; no done pulse SHALL follow.
REQ-024 The first start after reset release SHALL behave per REQ-010.

Structure
REQ-025 A shared package SHALL hold the constants NK=8, NR=14, NWORDS=60, the Rcon table, and the FSM state encoding.
REQ-026 SubWord SHALL instantiate four copies of one combinational sub-module, aes_sbox: 8-bit in, 8-bit out, the FIPS-197 S-box.
REQ-027 Only one word-compute datapath SHALL exist; no parallel word generation.

Verification
REQ-028 FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, one-cycle start -> keyExpDone at start+52; w8=9ba35411, w12=a8b09c1a, w59=706c631e.
REQ-029 Same run -> w56..w59 = fe4890d1 e6188d0b 046df344 706c631e; keyExpBusy high exactly 52 cycles.
REQ-030 Pulse enableKeyExp at cycle 20 of EXPAND, and change key to all zeros at cycle 10 -> results identical to REQ-028, done still at +52.
REQ-031 rst asserted at EXPAND cycle 30 -> keyExp=0, busy=0, done=0 next cycle; a new start with the all-zero key -> w8=62636363, w59 per FIPS-197 zero-key vector, done at +52.
REQ-032 Start in DONE with a new key -> done drops at that edge; busy high; new result after 52 cycles.
REQ-033 rst and enableKeyExp high at the same edge -> IDLE, all outputs zero, no expansion begins.

Source files
------------

// File: rtl/key_expansion_pkg.sv
// Shared constants, round-constant table and FSM encoding for the AES-256
// key expansion block.
package key_expansion_pkg;

    localparam int NK     = 8;
    localparam int NR     = 14;
    localparam int NWORDS = 4 * (NR + 1);

    localparam logic [5:0] FIRST_INDEX = 6'(NK);
    localparam logic [5:0] LAST_INDEX  = 6'(NWORDS - 1);

    // Byte r of this table is Rcon[r]; entry 0 is never used.
    localparam logic [0:63] RCON = 64'h00_01_02_04_08_10_20_40;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] rcon(input logic [2:0] round);
        return RCON[{round, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/key_expansion_sbox.sv
// FIPS-197 forward S-box as a combinational lookup table.
module aes_sbox (
    input  logic [7:0] byteIn,
    output logic [7:0] byteOut
);

    // Entry n occupies bits [8n : 8n+7]; rows are 16 entries each.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byteOut = SBOX[{byteIn, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion.sv
// AES-256 key expansion: loads the 8 key words on start, then produces one
// expanded word per clock until all 60 are valid.
module key_expansion
    import key_expansion_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           enableKeyExp,
    input  logic [0:255]   key,
    output logic [0:1919]  keyExp,
    output logic           keyExpBusy,
    output logic           keyExpDone
);

    state_t      state;
    state_t      nextState;
    logic        startRun;
    logic [5:0]  index;
    logic [31:0] words [NWORDS];

    logic [31:0] prevWord;
    logic [31:0] oldWord;
    logic [31:0] sboxIn;
    logic [31:0] subWord;
    logic [31:0] temp;
    logic [31:0] newWord;

    always_comb begin
        nextState  = state;
        startRun   = 1'b0;
        keyExpBusy = 1'b0;
        keyExpDone = 1'b0;
        case (state)
            IDLE: begin
                if (enableKeyExp) begin
                    startRun  = 1'b1;
                    nextState = EXPAND;
                end
            end
            EXPAND: begin
                keyExpBusy = 1'b1;
                if (index == LAST_INDEX) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                keyExpDone = 1'b1;
                if (enableKeyExp) begin
                    startRun  = 1'b1;
                    nextState = EXPAND;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
        end else if (startRun) begin
            index <= FIRST_INDEX;
        end else if (state == EXPAND && index != LAST_INDEX) begin
            index <= index + 6'd1;
        end
    end

    // Single word datapath: w[i] = w[i-8] ^ temp(w[i-1]).
    assign prevWord = words[index - 6'd1];
    assign oldWord  = words[index - 6'd8];
    assign sboxIn   = (index[2:0] == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byteIn  (sboxIn[8*b +: 8]),
            .byteOut (subWord[8*b +: 8])
        );
    end

    always_comb begin
        temp = prevWord;
        case (index[2:0])
            3'd0:    temp = subWord ^ {rcon(index[5:3]), 24'h000000};
            3'd4:    temp = subWord;
            default: temp = prevWord;
        endcase
    end

    assign newWord = oldWord ^ temp;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NWORDS; i++) begin
                words[i] <= '0;
            end
        end else if (startRun) begin
            for (int i = 0; i < NK; i++) begin
                words[i] <= key[32*i +: 32];
            end
        end else if (state == EXPAND) begin
            words[index] <= newWord;
        end
    end

    for (genvar w = 0; w < NWORDS; w++) begin : g_pack
        assign keyExp[32*w +: 32] = words[w];
    end

endmodule

// File: tb/tb_key_expansion.sv
// Directed, table-driven bench for key_expansion with an independent
// behavioural model (S-box derived from GF(2^8) inversion).
module tb_key_expansion;

    logic          clk = 1'b0;
    logic          rst;
    logic          enableKeyExp;
    logic [0:255]  key;
    logic [0:1919] keyExp;
    logic          keyExpBusy;
    logic          keyExpDone;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  sboxModel [256];
    logic [31:0] modelW    [60];

    localparam logic [0:255] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [0:255] KEY_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:255] KEY_ZERO = '0;

    typedef struct {
        logic [0:255] vecKey;
        int           idx;
        logic [31:0]  expWord;
    } vec_t;

    vec_t vectors[$];

    key_expansion dut (
        .clk          (clk),
        .rst          (rst),
        .enableKeyExp (enableKeyExp),
        .key          (key),
        .keyExp       (keyExp),
        .keyExpBusy   (keyExpBusy),
        .keyExpDone   (keyExpDone)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sboxModel[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWordModel(input logic [31:0] v);
        return {sboxModel[v[31:24]], sboxModel[v[23:16]], sboxModel[v[15:8]], sboxModel[v[7:0]]};
    endfunction

    task automatic modelExpand(input logic [0:255] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) modelW[i] = k[32*i +: 32];
        for (int i = 8; i < 60; i++) begin
            t = modelW[i-1];
            if (i % 8 == 0) begin
                rc = 8'h01 << (i / 8 - 1);
                t  = subWordModel({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (i % 8 == 4) begin
                t = subWordModel(t);
            end
            modelW[i] = modelW[i-8] ^ t;
        end
    endtask

    function automatic logic [31:0] getWord(input int i);
        return keyExp[32*i +: 32];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "Busy"}, 32'(keyExpBusy), 32'd0);
        checkOutput({tag, "Done"}, 32'(keyExpDone), 32'd0);
        checkOutput({tag, "KeyExpZero"}, 32'(|keyExp), 32'd0);
    endtask

    task automatic compareModel(input logic [0:255] k, input string tag);
        modelExpand(k);
        for (int i = 0; i < 60; i++) begin
            checkOutput($sformatf("%s_w%0d", tag, i), getWord(i), modelW[i]);
        end
    endtask

    // Drives a start at the next edge; returns at the negedge after it.
    task automatic applyStimulus(input logic [0:255] k, input logic hold);
        @(negedge clk);
        key          = k;
        enableKeyExp = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) enableKeyExp = 1'b0;
    endtask

    task automatic waitDone(input int keyZeroAt, input int pulseAt, output int lat, output int busyCnt);
        lat     = 0;
        busyCnt = 0;
        while (!keyExpDone && lat < 100) begin
            if (keyExpBusy) busyCnt++;
            checkOutput("busyDoneExclusive", 32'(keyExpBusy & keyExpDone), 32'd0);
            if (lat == keyZeroAt) key = '0;
            if (pulseAt >= 0 && lat == pulseAt) enableKeyExp = 1'b1;
            if (pulseAt >= 0 && lat == pulseAt + 1) enableKeyExp = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runAndCheck(input logic [0:255] k, input string tag);
        int lat;
        int busyCnt;
        applyStimulus(k, 1'b0);
        waitDone(-1, -1, lat, busyCnt);
        checkOutput({tag, "Latency"}, 32'(lat), 32'd52);
        checkOutput({tag, "BusyCycles"}, 32'(busyCnt), 32'd52);
        compareModel(k, tag);
    endtask

    initial begin
        logic [0:255] curKey;
        bit           haveRun;
        bit           sawDone;
        int           lat;
        int           busyCnt;

        rst          = 1'b1;
        enableKeyExp = 1'b0;
        key          = '0;
        buildSbox();

        vectors.push_back('{KEY_A3,    0, 32'h603deb10});
        vectors.push_back('{KEY_A3,    7, 32'h0914dff4});
        vectors.push_back('{KEY_A3,    8, 32'h9ba35411});
        vectors.push_back('{KEY_A3,   12, 32'ha8b09c1a});
        vectors.push_back('{KEY_A3,   56, 32'hfe4890d1});
        vectors.push_back('{KEY_A3,   57, 32'he6188d0b});
        vectors.push_back('{KEY_A3,   58, 32'h046df344});
        vectors.push_back('{KEY_A3,   59, 32'h706c631e});
        vectors.push_back('{KEY_ZERO,  0, 32'h00000000});
        vectors.push_back('{KEY_ZERO,  8, 32'h62636363});
        vectors.push_back('{KEY_ZERO, 11, 32'h62636363});
        vectors.push_back('{KEY_ZERO, 12, 32'haafbfbfb});

        repeat (3) @(negedge clk);
        checkIdleZero("reset");
        rst = 1'b0;
        @(negedge clk);
        checkIdleZero("afterRelease");

        haveRun = 1'b0;
        curKey  = '0;
        for (int v = 0; v < vectors.size(); v++) begin
            if (!haveRun || vectors[v].vecKey !== curKey) begin
                runAndCheck(vectors[v].vecKey, $sformatf("vecRun%0d", v));
                curKey  = vectors[v].vecKey;
                haveRun = 1'b1;
            end
            checkOutput($sformatf("vec%0d_w%0d", v, vectors[v].idx), getWord(vectors[v].idx), vectors[v].expWord);
        end

        // Start ignored mid-run and key changes after the start edge.
        applyStimulus(KEY_A3, 1'b0);
        waitDone(10, 20, lat, busyCnt);
        enableKeyExp = 1'b0;
        checkOutput("ignoreLatency", 32'(lat), 32'd52);
        checkOutput("ignoreW59", getWord(59), 32'h706c631e);
        compareModel(KEY_A3, "ignore");

        // Restart from DONE with a new key.
        applyStimulus(KEY_C3, 1'b0);
        checkOutput("restartDoneDrop", 32'(keyExpDone), 32'd0);
        checkOutput("restartBusy", 32'(keyExpBusy), 32'd1);
        waitDone(-1, -1, lat, busyCnt);
        checkOutput("restartLatency", 32'(lat), 32'd52);
        compareModel(KEY_C3, "restart");

        // Reset in the middle of an expansion aborts it.
        applyStimulus(KEY_A3, 1'b0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdleZero("midReset");
        sawDone = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (keyExpDone || keyExpBusy) sawDone = 1'b1;
        end
        checkOutput("noDoneAfterAbort", 32'(sawDone), 32'd0);
        runAndCheck(KEY_ZERO, "zeroKey");
        checkOutput("zeroKeyW8", getWord(8), 32'h62636363);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst          = 1'b1;
        enableKeyExp = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        enableKeyExp = 1'b0;
        checkIdleZero("rstVsStart");
        repeat (3) @(negedge clk);
        checkIdleZero("rstVsStartHold");

        // Held-high start re-triggers once DONE is reached.
        applyStimulus(KEY_A3, 1'b1);
        waitDone(-1, -1, lat, busyCnt);
        checkOutput("levelLatency", 32'(lat), 32'd52);
        @(negedge clk);
        enableKeyExp = 1'b0;
        checkOutput("levelRestartBusy", 32'(keyExpBusy), 32'd1);
        checkOutput("levelRestartDone", 32'(keyExpDone), 32'd0);
        waitDone(-1, -1, lat, busyCnt);
        checkOutput("levelSecondLatency", 32'(lat), 32'd52);
        compareModel(KEY_A3, "level");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
